// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch definitions: FSM encodings, reset defaults and PC helpers,
// also used by the core's PC/branch logic.
package inst_fetch_unit_pkg;

   localparam logic [1:0] STATE_IDLE = 2'd0;
   localparam logic [1:0] STATE_WAIT = 2'd1;
   localparam logic [1:0] STATE_DROP = 2'd2;

   localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;
   localparam logic [31:0] PC_INC             = 32'd4;
   localparam int          ENTRY_W            = 64;

   // Instruction addresses are always word aligned.
   function automatic logic [31:0] alignAddr(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// Small prefetch FIFO holding {pc, inst} entries; flush empties it in one edge
// and takes priority over push/pop.
module inst_fetch_unit_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] pushData,
   output logic [WIDTH-1:0] headData,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W-1:0] wrPtr;
   logic [CNT_W-1:0] count;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign headData = mem[rdPtr];
   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);

   // Storage is cleared on reset so the head reads as zero until the first push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else if (flush) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wrPtr] <= pushData;
            wrPtr      <= nextPtr(wrPtr);
         end
         if (pop) begin
            rdPtr <= nextPtr(rdPtr);
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one memory read in flight
// and buffers returned words for the core in a 2-entry prefetch FIFO.
module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_addr
);

   logic [1:0]         state;
   logic [1:0]         stateNext;
   logic [31:0]        fetchPc;
   logic [31:0]        fetchPcNext;
   logic [31:0]        reqAddr;
   logic               launch;
   logic               push;
   logic               pop;
   logic               fifoFull;
   logic               fifoEmpty;
   logic [ENTRY_W-1:0] headEntry;

   // A new read only starts when the FIFO has room for its result.
   assign launch     = (state == STATE_IDLE) && !redirect && !fifoFull;
   assign push       = (state == STATE_WAIT) && imem_ack && !redirect;
   assign pop        = inst_valid && inst_ready;

   assign imem_req   = (state != STATE_IDLE);
   assign imem_addr  = imem_req ? reqAddr : fetchPc;
   assign inst_valid = !fifoEmpty;
   assign inst       = headEntry[31:0];
   assign inst_pc    = headEntry[63:32];

   // Next-state and PC update; an ack arriving outside WAIT/DROP is ignored.
   always_comb begin
      stateNext   = state;
      fetchPcNext = fetchPc;
      case (state)
         STATE_IDLE: begin
            if (redirect) begin
               fetchPcNext = alignAddr(redirect_addr);
            end else if (launch) begin
               stateNext = STATE_WAIT;
            end
         end
         STATE_WAIT: begin
            if (redirect) begin
               fetchPcNext = alignAddr(redirect_addr);
               stateNext   = imem_ack ? STATE_IDLE : STATE_DROP;
            end else if (imem_ack) begin
               fetchPcNext = reqAddr + PC_INC;
               stateNext   = STATE_IDLE;
            end
         end
         STATE_DROP: begin
            if (redirect) begin
               fetchPcNext = alignAddr(redirect_addr);
            end
            if (imem_ack) begin
               stateNext = STATE_IDLE;
            end
         end
         default: begin
            stateNext = STATE_IDLE;
         end
      endcase
   end

   // reqAddr is latched at launch so the address stays put even if a redirect
   // moves fetchPc while the read is still outstanding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= STATE_IDLE;
         fetchPc <= RESET_ADDR;
         reqAddr <= RESET_ADDR;
      end else begin
         state   <= stateNext;
         fetchPc <= fetchPcNext;
         if (launch) begin
            reqAddr <= fetchPc;
         end
      end
   end

   inst_fetch_unit_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) fetchFifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .pop      (pop),
      .flush    (redirect),
      .pushData ({reqAddr, imem_rdata}),
      .headData (headEntry),
      .full     (fifoFull),
      .empty    (fifoEmpty)
   );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a main instance at reset address 0 and a
// second instance at the top of memory to exercise PC wrap-around.
module tb_inst_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemAck;
   logic [31:0] imemRdata;
   logic [31:0] inst;
   logic [31:0] instPc;
   logic        instValid;
   logic        instReady;
   logic        redirect;
   logic [31:0] redirectAddr;

   logic        hiReq;
   logic [31:0] hiAddr;
   logic        hiAck;
   logic [31:0] hiRdata;
   logic [31:0] hiInst;
   logic [31:0] hiInstPc;
   logic        hiValid;

   int compared;
   int mismatched;

   inst_fetch_unit #(.RESET_ADDR(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imemReq),
      .imem_addr     (imemAddr),
      .imem_ack      (imemAck),
      .imem_rdata    (imemRdata),
      .inst          (inst),
      .inst_pc       (instPc),
      .inst_valid    (instValid),
      .inst_ready    (instReady),
      .redirect      (redirect),
      .redirect_addr (redirectAddr)
   );

   inst_fetch_unit #(.RESET_ADDR(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dutHi (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (hiReq),
      .imem_addr     (hiAddr),
      .imem_ack      (hiAck),
      .imem_rdata    (hiRdata),
      .inst          (hiInst),
      .inst_pc       (hiInstPc),
      .inst_valid    (hiValid),
      .inst_ready    (1'b1),
      .redirect      (1'b0),
      .redirect_addr (32'h0000_0000)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] expData(input logic [31:0] addr);
      return 32'hC0DE_0000 ^ addr;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic ack, input logic [31:0] rdata, input logic ready,
                                input logic redir, input logic [31:0] redirAddr);
      imemAck      = ack;
      imemRdata    = rdata;
      instReady    = ready;
      redirect     = redir;
      redirectAddr = redirAddr;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkBit(input string tag, input logic observed, input logic expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst_n      = 1'b0;
      hiAck      = 1'b0;
      hiRdata    = 32'h0;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      tick();
      tick();
      checkBit("reset req", imemReq, 1'b0);
      checkOutput("reset addr", imemAddr, 32'h0);
      checkBit("reset valid", instValid, 1'b0);
      checkOutput("reset inst", inst, 32'h0);
      checkOutput("reset pc", instPc, 32'h0);
      rst_n = 1'b1;

      // Sequential fetch, one-cycle memory, core always ready.
      for (int i = 0; i < 4; i++) begin
         logic [31:0] a;
         a = 32'(i * 4);
         tick();
         checkBit("t1 req", imemReq, 1'b1);
         checkOutput("t1 addr", imemAddr, a);
         if (i == 0) begin
            tick();
            checkBit("t1 req held", imemReq, 1'b1);
            checkOutput("t1 addr held", imemAddr, a);
         end
         applyStimulus(1'b1, expData(a), 1'b1, 1'b0, 32'h0);
         tick();
         checkBit("t1 valid", instValid, 1'b1);
         checkOutput("t1 inst_pc", instPc, a);
         checkOutput("t1 inst", inst, expData(a));
         checkBit("t1 req idle", imemReq, 1'b0);
         applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      end
      tick();
      checkBit("t6 req before reset", imemReq, 1'b1);
      checkOutput("t6 addr before reset", imemAddr, 32'h10);

      // Reset while a read is outstanding, then a stale ack after release.
      rst_n = 1'b0;
      #1;
      checkBit("t6 async req", imemReq, 1'b0);
      checkOutput("t6 async addr", imemAddr, 32'h0);
      checkBit("t6 async valid", instValid, 1'b0);
      checkOutput("t6 async inst", inst, 32'h0);
      checkOutput("t6 async pc", instPc, 32'h0);
      tick();
      rst_n = 1'b1;
      applyStimulus(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0);
      tick();
      checkBit("t6 stale ack valid", instValid, 1'b0);
      checkBit("t6 req after release", imemReq, 1'b1);
      checkOutput("t6 addr after release", imemAddr, 32'h0);

      // Core stalled, memory always acks: two words buffered, then drain.
      applyStimulus(1'b1, expData(32'h0), 1'b0, 1'b0, 32'h0);
      tick();
      checkBit("t2 valid", instValid, 1'b1);
      checkOutput("t2 pc0", instPc, 32'h0);
      checkOutput("t2 inst0", inst, expData(32'h0));
      applyStimulus(1'b1, expData(32'h4), 1'b0, 1'b0, 32'h0);
      tick();
      checkBit("t2 req 4", imemReq, 1'b1);
      checkOutput("t2 addr 4", imemAddr, 32'h4);
      tick();
      checkBit("t2 req full a", imemReq, 1'b0);
      tick();
      checkBit("t2 req full b", imemReq, 1'b0);
      checkOutput("t2 head still 0", instPc, 32'h0);
      applyStimulus(1'b1, expData(32'h8), 1'b1, 1'b0, 32'h0);
      tick();
      checkOutput("t2 pc4", instPc, 32'h4);
      checkOutput("t2 inst4", inst, expData(32'h4));
      checkBit("t2 req after pop", imemReq, 1'b0);
      tick();
      checkBit("t2 req 8", imemReq, 1'b1);
      checkOutput("t2 addr 8", imemAddr, 32'h8);
      checkBit("t2 drained", instValid, 1'b0);
      tick();
      checkBit("t2 valid 8", instValid, 1'b1);
      checkOutput("t2 pc8", instPc, 32'h8);
      checkOutput("t2 inst8", inst, expData(32'h8));

      // Redirect while a read is outstanding: result dropped, fetch restarts.
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h10);
      tick();
      checkBit("t3 flushed", instValid, 1'b0);
      checkOutput("t3 idle addr", imemAddr, 32'h10);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      tick();
      checkBit("t3 req 10", imemReq, 1'b1);
      checkOutput("t3 addr 10", imemAddr, 32'h10);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h103);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkBit("t3 drop req", imemReq, 1'b1);
      checkOutput("t3 drop addr a", imemAddr, 32'h10);
      tick();
      tick();
      checkOutput("t3 drop addr b", imemAddr, 32'h10);
      applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
      tick();
      checkBit("t3 dropped valid", instValid, 1'b0);
      checkBit("t3 req after drop", imemReq, 1'b0);
      checkOutput("t3 next addr", imemAddr, 32'h100);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      tick();
      checkBit("t3 req 100", imemReq, 1'b1);
      checkOutput("t3 addr 100", imemAddr, 32'h100);
      applyStimulus(1'b1, expData(32'h100), 1'b1, 1'b0, 32'h0);
      tick();
      checkBit("t3 valid 100", instValid, 1'b1);
      checkOutput("t3 pc 100", instPc, 32'h100);
      checkOutput("t3 inst 100", inst, expData(32'h100));
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

      // Redirect in the same cycle as the ack.
      tick();
      checkOutput("t4 addr 104", imemAddr, 32'h104);
      applyStimulus(1'b1, 32'h0BAD_0BAD, 1'b1, 1'b1, 32'h20B);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkBit("t4 not pushed", instValid, 1'b0);
      checkBit("t4 idle", imemReq, 1'b0);
      checkOutput("t4 redirect addr", imemAddr, 32'h208);
      tick();
      checkBit("t4 req 208", imemReq, 1'b1);
      checkOutput("t4 addr 208", imemAddr, 32'h208);
      applyStimulus(1'b1, expData(32'h208), 1'b1, 1'b0, 32'h0);
      tick();
      checkBit("t4 valid 208", instValid, 1'b1);
      checkOutput("t4 pc 208", instPc, 32'h208);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

      // PC wrap-around from the top of memory.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checkBit("t5 reset req", hiReq, 1'b0);
      checkOutput("t5 reset addr", hiAddr, 32'hFFFF_FFFC);
      tick();
      checkBit("t5 req top", hiReq, 1'b1);
      checkOutput("t5 addr top", hiAddr, 32'hFFFF_FFFC);
      hiAck   = 1'b1;
      hiRdata = 32'h1234_5678;
      tick();
      hiAck   = 1'b0;
      checkBit("t5 valid", hiValid, 1'b1);
      checkOutput("t5 inst_pc", hiInstPc, 32'hFFFF_FFFC);
      checkOutput("t5 inst", hiInst, 32'h1234_5678);
      checkOutput("t5 wrapped pc", hiAddr, 32'h0);
      tick();
      checkBit("t5 req wrapped", hiReq, 1'b1);
      checkOutput("t5 addr wrapped", hiAddr, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
